// File: rtl/shift_seq_ctrl.sv
// Multi-cycle SLL/SRL/SRA sequencer: shifts by up to STEP bits per clock with start/done handshake.
// Optional SHIFT_SEQ_EARLY_EXIT_EN finishes as soon as the working value is saturated.
module shift_seq_ctrl #(
  parameter int unsigned STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [4:0]  shamt,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [4:0] STEP_AMT = 5'(STEP);

  logic [1:0]  r_state;
  logic [1:0]  w_state_d;
  logic [31:0] r_work;
  logic [4:0]  r_rem;
  logic        r_left;
  logic        r_fill;
  logic [31:0] r_result;

  logic        w_accept;
  logic [4:0]  w_amt;
  logic [4:0]  w_rem_next;
  logic [31:0] w_shifted;
  logic        w_finish;

  assign w_accept   = start & ~abort & (r_state != ST_SHIFT);
  assign w_amt      = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;
  assign w_rem_next = r_rem - w_amt;

  // r_fill is the captured sign for SRA and 0 for SRL, so one OR covers both right shifts.
  always_comb begin
    w_shifted = r_work;
    if (r_left) begin
      w_shifted = r_work << w_amt;
    end else begin
      w_shifted = (r_work >> w_amt) | (r_fill ? ~(32'hFFFF_FFFF >> w_amt) : 32'h0000_0000);
    end
  end

`ifdef SHIFT_SEQ_EARLY_EXIT_EN
  logic w_sat;
  assign w_sat    = (w_shifted == {32{r_fill}});
  assign w_finish = (w_rem_next == 5'd0) | w_sat;
`else
  assign w_finish = (w_rem_next == 5'd0);
`endif

  always_comb begin
    w_state_d = r_state;
    if (abort) begin
      w_state_d = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_state_d = (shamt == 5'd0) ? ST_DONE : ST_SHIFT;
          end else begin
            w_state_d = ST_IDLE;
          end
        end
        ST_SHIFT: begin
          w_state_d = w_finish ? ST_DONE : ST_SHIFT;
        end
        default: w_state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_work   <= 32'h0000_0000;
      r_rem    <= 5'd0;
      r_left   <= 1'b0;
      r_fill   <= 1'b0;
      r_result <= 32'h0000_0000;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_work <= a;
        r_rem  <= shamt;
        r_left <= (op == 2'b00);
        r_fill <= op[1] & a[31];
        if (shamt == 5'd0) begin
          r_result <= a;
        end
      end else if ((r_state == ST_SHIFT) && !abort) begin
        r_work <= w_shifted;
        r_rem  <= w_rem_next;
        if (w_finish) begin
          r_result <= w_shifted;
        end
      end
    end
  end

  assign busy   = (r_state == ST_SHIFT);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

endmodule
